// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus used by the fetch stage.
//
// Handshake: the master raises req with a stable addr and holds both until
// the slave answers with gnt in the same cycle. req and addr may change
// only after a granted cycle, or when the master withdraws the request.
// One rvalid/rdata beat returns per grant, at the earliest one cycle after
// gnt. rvalid has no back-pressure: the master must take it when offered.
//
// Signals:
//   req     master -> slave  read request
//   addr    master -> slave  word address (bits [1:0] always zero)
//   gnt     slave  -> master request accepted this cycle
//   rvalid  slave  -> master read data valid
//   rdata   slave  -> master instruction word
interface instr_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. Latches the PC, reads one word from instruction
// memory, holds it for decode and exposes the decoded immediate fields.
// A flush discards any in-flight or held instruction.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   pc             current PC from the PC counter
//   fetch_en       permits starting a new fetch
//   flush          redirect: drop in-flight/held instruction, clear addr_err
//   imem           instruction-memory bus (master side)
//   inst_valid     held instruction available to decode
//   inst_ready     decode consumes the held instruction
//   inst, inst_pc  held instruction and the PC it was fetched from
//   opcode, sign_imm, jump_low_26   fields decoded from inst
//   pc_advance     one-cycle pulse on each accepted instruction
//   addr_err       sticky: misaligned PC presented while fetching
//   fsm_state      debug view of the FSM (0 IDLE, 1 REQ, 2 WAIT, 3 HOLD)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               pc,
  input  logic                      fetch_en,
  input  logic                      flush,
  instr_fetch_unit_if.master        imem,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst,
  output logic [31:0]               inst_pc,
  output logic [5:0]                opcode,
  output logic [31:0]               sign_imm,
  output logic [25:0]               jump_low_26,
  output logic                      pc_advance,
  output logic                      addr_err,
  output logic [1:0]                fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        drop_q, drop_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        pc_misaligned;

  assign pc_misaligned = (pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      drop_q     <= 1'b0;
      addr_err_q <= 1'b0;
      addr_q     <= 32'h0;
      inst_q     <= 32'h0;
      inst_pc_q  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      addr_err_q <= addr_err_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    addr_d     = addr_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    // flush is the only way (besides reset) to clear the sticky error
    addr_err_d = addr_err_q && !flush;
    pc_advance = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fetch_en && !flush && pc_misaligned) begin
          addr_err_d = 1'b1;
        end else if (fetch_en && !flush && !addr_err_q) begin
          addr_d  = pc;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Once granted, the memory will answer; a concurrent flush can only
        // mark that answer for disposal.
        if (imem.gnt) begin
          drop_d  = flush;
          state_d = S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            inst_d    = imem.rdata;
            inst_pc_d = addr_q;
            state_d   = S_HOLD;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (inst_ready) begin
          pc_advance = 1'b1;
          // Back-to-back fetch latches the PC as presented now, i.e. before
          // the PC counter reacts to this pc_advance.
          if (fetch_en && !pc_misaligned) begin
            addr_d  = pc;
            state_d = S_REQ;
          end else begin
            if (fetch_en) addr_err_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem.req    = (state_q == S_REQ);
  assign imem.addr   = addr_q;
  assign inst_valid  = (state_q == S_HOLD);
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign opcode      = inst_q[31:26];
  assign sign_imm    = {{16{inst_q[15]}}, inst_q[15:0]};
  assign jump_low_26 = inst_q[25:0];
  assign addr_err    = addr_err_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by a
// randomized run against a sequential-PC reference model.
module tb_instr_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [31:0] pc = 32'h0;
  logic        fetch_en = 1'b0;
  logic        flush = 1'b0;
  logic        inst_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst, inst_pc, sign_imm;
  logic [5:0]  opcode;
  logic [25:0] jump_low_26;
  logic        pc_advance, addr_err;
  logic [1:0]  fsm_state;

  instr_fetch_unit_if imem ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .imem(imem), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .opcode(opcode), .sign_imm(sign_imm),
    .jump_low_26(jump_low_26), .pc_advance(pc_advance), .addr_err(addr_err),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h2008_FFFC;
      32'h0000_0080: return 32'h0810_0010;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endcase
  endfunction

  // ---------------- memory responder ----------------
  int   gnt_wait = 0;
  int   gnt_wait_cfg = 0;
  int   lat_cfg = 1;
  int   rv_cnt = 0;
  bit   gnt_rand = 1'b0;
  bit   lat_rand = 1'b0;
  logic [31:0] rv_addr = 32'h0;

  initial begin : mem_model
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;
    forever begin
      @(negedge clk);
      imem.gnt = 1'b0; imem.rvalid = 1'b0;
      if (!rst_n) begin
        rv_cnt = 0;
        gnt_wait = gnt_wait_cfg;
      end else begin
        if (rv_cnt > 0) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            imem.rvalid = 1'b1;
            imem.rdata  = mem_word(rv_addr);
          end
        end
        if (!imem.req) begin
          gnt_wait = gnt_rand ? int'($urandom_range(0, 3)) : gnt_wait_cfg;
        end else if (gnt_wait > 0) begin
          gnt_wait--;
        end else begin
          imem.gnt = 1'b1;
          rv_addr  = imem.addr;
          rv_cnt   = lat_rand ? int'($urandom_range(1, 3)) : lat_cfg;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs();
    check("rst_req", imem.req, 0);
    check("rst_addr", imem.addr, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_adv", pc_advance, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_state", fsm_state, 0);
  endtask

  // One-cycle fetch_en at address a, then wait (bounded) for inst_valid.
  task automatic fetch_at(input logic [31:0] a);
    bit seen;
    @(negedge clk);
    pc = a; fetch_en = 1'b1; inst_ready = 1'b0; flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      fetch_en = 1'b0;
      #1;
      if (inst_valid) seen = 1'b1;
    end
    check("fetch_done", seen, 1);
  endtask

  task automatic consume();
    @(negedge clk);
    inst_ready = 1'b1;
    #1;
    check("adv_pulse", pc_advance, 1);
    @(negedge clk);
    inst_ready = 1'b0;
    #1;
    check("adv_once", pc_advance, 0);
    check("valid_drop", inst_valid, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int req_cycles, grants, episodes, addr_bad, consumed, first_adv, gap, adv_count;
    bit prev_v, v_seen, a_seen, rv_seen, adv_pending;
    logic prev_req, prev_gnt, prev_flush, prev_valid, prev_ready;
    logic [31:0] prev_addr, prev_inst, exp_pc, exp_word;

    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // single fetch, zero-wait memory, minimum latency
    @(negedge clk);
    pc = 32'h40; fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    #1;
    check("t1_req", imem.req, 1);
    check("t1_addr", imem.addr, 32'h40);
    @(negedge clk);
    #1;
    check("t1_early_valid", inst_valid, 0);
    @(negedge clk);
    #1;
    check("t1_valid", inst_valid, 1);
    check("t1_inst", inst, 32'h2008_FFFC);
    check("t1_sign_imm", sign_imm, 32'hFFFF_FFFC);
    check("t1_opcode", opcode, 6'h08);
    check("t1_inst_pc", inst_pc, 32'h40);
    consume();

    // jump decode
    fetch_at(32'h80);
    check("t2_opcode", opcode, 6'h02);
    check("t2_jump", jump_low_26, 26'h010_0010);
    check("t2_sign_imm", sign_imm, 32'h0000_0010);
    consume();

    // grant stall: gnt low for 4 cycles
    gnt_wait_cfg = 4;
    @(negedge clk);
    pc = 32'h48; fetch_en = 1'b1;
    req_cycles = 0; grants = 0; episodes = 0; addr_bad = 0; prev_v = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      fetch_en = 1'b0;
      pc = 32'h1234_5670;
      inst_ready = inst_valid;
      #1;
      if (imem.req) begin
        req_cycles++;
        if (imem.addr !== 32'h48) addr_bad++;
        if (imem.gnt) grants++;
      end
      if (inst_valid && !prev_v) episodes++;
      prev_v = inst_valid;
    end
    inst_ready = 1'b0;
    gnt_wait_cfg = 0;
    check("t3_req_cycles", req_cycles, 5);
    check("t3_addr_stable", addr_bad, 0);
    check("t3_grants", grants, 1);
    check("t3_episodes", episodes, 1);
    check("t3_inst_pc", inst_pc, 32'h48);

    // flush one cycle after grant, rvalid two cycles after the flush
    lat_cfg = 3;
    @(negedge clk);
    pc = 32'h50; fetch_en = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    #1;
    check("t4_gnt", imem.gnt, 1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    v_seen = 1'b0; a_seen = 1'b0; rv_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      v_seen  = v_seen | inst_valid;
      a_seen  = a_seen | pc_advance;
      rv_seen = rv_seen | imem.rvalid;
    end
    check("t4_rvalid_came", rv_seen, 1);
    check("t4_no_valid", v_seen, 0);
    check("t4_no_adv", a_seen, 0);
    check("t4_idle", fsm_state, 0);
    check("t4_no_req", imem.req, 0);
    lat_cfg = 1;
    inst_ready = 1'b0;

    // misaligned PC, sticky error, clear by flush
    @(negedge clk);
    pc = 32'h42; fetch_en = 1'b1;
    @(negedge clk);
    #1;
    check("t5_addr_err", addr_err, 1);
    check("t5_no_req", imem.req, 0);
    @(negedge clk);
    pc = 32'h44;
    #1;
    check("t5_no_req2", imem.req, 0);
    @(negedge clk);
    #1;
    check("t5_sticky", addr_err, 1);
    check("t5_blocked", imem.req, 0);
    @(negedge clk);
    fetch_en = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("t5_cleared", addr_err, 0);
    fetch_at(32'h44);
    check("t5_inst_pc", inst_pc, 32'h44);
    check("t5_inst", inst, mem_word(32'h44));
    consume();

    // backpressure then reset in HOLD
    fetch_at(32'h60);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("t6_hold_valid", inst_valid, 1);
      check("t6_hold_inst", inst, mem_word(32'h60));
      check("t6_hold_adv", pc_advance, 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // back-to-back throughput with ready held high
    @(negedge clk);
    pc = 32'h70; fetch_en = 1'b1; inst_ready = 1'b1;
    first_adv = -1; gap = 0; adv_count = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (pc_advance) begin
        adv_count++;
        check("t7_inst_pc", inst_pc, 32'h70);
        if (adv_count == 1) first_adv = i;
        if (adv_count == 2) gap = i - first_adv;
      end
    end
    check("t7_gap", gap, 3);
    check("t7_count", adv_count >= 6, 1);
    fetch_en = 1'b0;
    repeat (6) @(negedge clk);
    inst_ready = 1'b0;

    // randomized run: consumed instructions must come from sequential PCs
    gnt_rand = 1'b1; lat_rand = 1'b1;
    @(negedge clk);
    pc = 32'h1000;
    exp_q.delete();
    exp_q.push_back(32'h1000);
    consumed = 0; adv_pending = 1'b0;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_flush = 1'b0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_addr = 32'h0; prev_inst = 32'h0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      if (adv_pending) begin
        pc = pc + 32'd4;
        adv_pending = 1'b0;
      end
      flush      = ($urandom_range(0, 24) == 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      fetch_en   = ($urandom_range(0, 2) != 0) && !(inst_valid && inst_ready);
      #1;
      if (prev_req && !prev_gnt && !prev_flush) begin
        check("rnd_req_hold", imem.req, 1);
        check("rnd_addr_hold", imem.addr, prev_addr);
      end
      if (prev_valid && !prev_ready && !prev_flush) begin
        check("rnd_valid_hold", inst_valid, 1);
        check("rnd_inst_hold", inst, prev_inst);
      end
      if (inst_valid && inst_ready && !flush) begin
        exp_pc   = exp_q.pop_front();
        exp_word = mem_word(exp_pc);
        check("rnd_adv", pc_advance, 1);
        check("rnd_inst_pc", inst_pc, exp_pc);
        check("rnd_inst", inst, exp_word);
        check("rnd_opcode", opcode, exp_word[31:26]);
        check("rnd_sign_imm", sign_imm, {{16{exp_word[15]}}, exp_word[15:0]});
        check("rnd_jump", jump_low_26, exp_word[25:0]);
        exp_q.push_back(exp_pc + 32'd4);
        adv_pending = 1'b1;
        consumed++;
      end else begin
        check("rnd_no_adv", pc_advance, 0);
      end
      prev_req   = imem.req;
      prev_gnt   = imem.gnt;
      prev_flush = flush;
      prev_valid = inst_valid;
      prev_ready = inst_ready;
      prev_addr  = imem.addr;
      prev_inst  = inst;
    end
    check("rnd_consumed", consumed >= 30, 1);
    flush = 1'b0; fetch_en = 1'b0; inst_ready = 1'b0;

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that sits directly downstream of the PC counter. It takes the current PC, issues a word read to instruction memory over a request/grant/response handshake and holds the returned instruction for decode. It also produces the sign-extended immediate and the 26-bit jump target that feed back into PC-next selection. It emits a one-cycle `pc_advance` pulse so the PC updates exactly once per accepted instruction; in-flight fetches are discarded on redirect (`flush`).

## Interface
- RESET_PC, 32'h0000_0000, value reported on `inst_pc` while no instruction has been captured
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- pc  in  32  current PC from the PC counter
- fetch_en  in  1  permits starting a new fetch
- flush  in  1  redirect; drop any in-flight or held instruction
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  word address of the request (latched PC)
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  read data valid; earliest one cycle after `imem_gnt`
- imem_rdata  in  32  instruction word
- inst_valid  out  1  held instruction available to decode
- inst_ready  in  1  decode consumes the instruction
- inst  out  32  held instruction word
- inst_pc  out  32  PC the held instruction was fetched from
- opcode  out  6  `inst[31:26]`
- sign_imm  out  32  `{{16{inst[15]}}, inst[15:0]}`
- jump_low_26  out  26  `inst[25:0]`
- pc_advance  out  1  one-cycle pulse when `inst_valid && inst_ready`
- addr_err  out  1  sticky flag: misaligned PC presented while fetching

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. Also a 1-bit `drop` flag that marks a granted fetch which must be discarded.
- IDLE:
  - `fetch_en && !flush && !addr_err && pc[1:0]==0`: latch `pc` into the address register, go to REQ.
  - `fetch_en && pc[1:0]!=0`: set `addr_err`, issue no request, stay in IDLE.
- REQ:
  - `imem_req=1` and `imem_addr` = latched PC, both held stable until grant.
  - `imem_gnt` goes to WAIT; `drop` takes the value of `flush` in that same cycle.
  - `flush` without `imem_gnt` withdraws the request and goes to IDLE.
- WAIT:
  - `imem_req=0`.
  - `imem_rvalid` with `drop==0` and `flush==0`: capture `imem_rdata` and the latched PC, go to HOLD.
  - `imem_rvalid` with `drop==1` or `flush==1`: discard the data, clear `drop`, go to IDLE.
  - `flush` without `imem_rvalid`: set `drop`, stay in WAIT.
- HOLD:
  - `inst_valid=1`; `inst`, `inst_pc` and the decoded fields stay stable.
  - `inst_ready`: pulse `pc_advance`. Then go to IDLE if `fetch_en==0`, otherwise to REQ, latching the current `pc` (back-to-back fetch).
  - `flush`: drop the instruction, go to IDLE with no `pc_advance`. Flush has priority over `inst_ready`.
- `addr_err` is cleared only by `flush` or reset. While it is set, no fetch starts.
- `sign_imm`, `opcode` and `jump_low_26` are combinational from the held `inst` register. They are only meaningful while `inst_valid=1`.

## Timing
- Reset values:
  - state IDLE, `drop=0`
  - `imem_req=0`, `imem_addr=0`
  - `inst_valid=0`, `inst=0`, `inst_pc=RESET_PC`
  - `pc_advance=0`, `addr_err=0`
- Minimum latency from IDLE: `fetch_en` in cycle 0, REQ in cycle 1 (granted in cycle 1), `rvalid` in cycle 2, `inst_valid` in cycle 3.
- Back-to-back throughput with zero-wait memory and `inst_ready` held high: one instruction every 3 cycles.
- `pc_advance` lasts one cycle and coincides with the HOLD handshake cycle. The PC counter updates on the following edge, so the PC latched on a direct HOLD-to-REQ transition is the old PC. The decode stage must deassert `inst_ready`, or the system must hold `fetch_en` low for one cycle, when a new PC is required. The team's pipeline holds `fetch_en` low in the handshake cycle.
- Simultaneous events:
  - `flush` with `imem_gnt` in REQ: go to WAIT with `drop=1`.
  - `flush` with `imem_rvalid` in WAIT: discard.
  - `flush` with `inst_ready` in HOLD: flush wins.
- Reset mid-operation returns to the reset values in one cycle. The bench must not drive a stale `imem_rvalid` after reset.

## Test plan
- Single fetch: `pc=0x0000_0040`, `rdata=0x2008FFFC`, zero-wait memory -> `imem_addr=0x40` in cycle 1; in cycle 3 `inst_valid=1`, `sign_imm=0xFFFF_FFFC`, `opcode=0x08`, `inst_pc=0x40`; `pc_advance` pulses on the ready cycle.
- Jump decode: `rdata=0x0810_0010` -> `opcode=0x02`, `jump_low_26=0x010_0010`.
- Grant stall: `imem_gnt` low for 4 cycles -> `imem_req` and `imem_addr` stable all 4 cycles, a single grant, exactly one `inst_valid` episode.
- Flush in WAIT: flush 1 cycle after grant, `rvalid` 2 cycles later -> no `inst_valid`, state IDLE, `pc_advance` never asserted.
- Misaligned PC: `pc=0x0000_0042`, `fetch_en=1` -> `addr_err=1`, `imem_req` stays 0; after a `flush` pulse, `addr_err=0` and a fetch at `0x44` proceeds normally.
- Backpressure and reset: `inst_ready=0` for 5 cycles holds `inst` constant with `pc_advance=0`; `rst_n=0` in HOLD gives all outputs at reset values on the next cycle.
